// File: rtl/mul8u_share_arb.sv
// Round-robin sharing of one external 8x8 multiplier among NUM_REQ valid/ready requesters.
// Optional error statistics versus an exact product are enabled by defining MUL_ERR_STAT_EN.
module mul8u_share_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int LAT     = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_z,
  output logic                 busy
`ifdef MUL_ERR_STAT_EN
  ,
  input  logic                 clr_stat,
  output logic [15:0]          err_max,
  output logic [15:0]          err_cnt
`endif
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  // vld_pipe[0] is S0 (operand register), vld_pipe[LAT] drives the response
  logic [LAT:0]           vld_pipe;
  logic [LAT:0][ID_W-1:0] id_q;
  logic [LAT:1][15:0]     z_q;
  logic [7:0]             a_q, b_q;
  logic [ID_W-1:0]        ptr_q, ptr_d, gnt;
  logic [ID_W:0]          cand;
  logic                   any_vld, stall, accept;

  // Scan from the highest offset down so the nearest requester after ptr wins
  always_comb begin
    gnt     = '0;
    any_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt     = cand[ID_W-1:0];
        any_vld = 1'b1;
      end
    end
  end

  assign stall     = vld_pipe[LAT] & ~rsp_ready;
  assign accept    = any_vld & ~stall;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;
  assign ptr_d     = accept ? ((gnt == LAST) ? '0 : gnt + 1'b1) : ptr_q;

  // Global stall: nothing moves, bubbles included, so rsp_* hold while blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_q     <= '0;
      z_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ptr_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (!stall) begin
        vld_pipe <= {vld_pipe[LAT-1:0], accept};
        if (accept) begin
          a_q     <= req_a[8*gnt +: 8];
          b_q     <= req_b[8*gnt +: 8];
          id_q[0] <= gnt;
        end
        z_q[1] <= mul_o;
        for (int s = 1; s <= LAT; s++) id_q[s] <= id_q[s-1];
        for (int s = 2; s <= LAT; s++) z_q[s]  <= z_q[s-1];
      end
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = vld_pipe[LAT];
  assign rsp_id    = id_q[LAT];
  assign rsp_z     = z_q[LAT];
  assign busy      = |vld_pipe;

`ifdef MUL_ERR_STAT_EN
  logic [LAT:1][15:0] ex_q;
  logic [15:0]        diff, err_max_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q[1] <= 16'(a_q) * 16'(b_q);
      for (int s = 2; s <= LAT; s++) ex_q[s] <= ex_q[s-1];
    end
  end

  assign diff = (rsp_z >= ex_q[LAT]) ? rsp_z - ex_q[LAT] : ex_q[LAT] - rsp_z;

  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (diff > err_max_q) err_max_q <= diff;
      if (diff != '0 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
